imem_loader: RTL and testbench

- Writer side of the instruction memory read by the fetch/decode queue.
- Receives a byte stream from a host link (UART or JTAG bridge) and packs it into 32-bit instruction words.
- Writes each word sequentially into instruction memory.
- Holds the CPU in reset until the image is complete, then releases it.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/imem_loader_if.sv | 30 +++
 rtl/byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Definitions shared by the image loader and the fetch/decode queue:
//   - MEMORY_BITS / MEMORY_SIZE : instruction memory geometry (words)
//   - HDR_BYTES                 : header length of a load frame (count lo, hi)
//   - state_t                   : loader state encoding
//   - accepts_start()           : states in which a start pulse begins a load
// -----------------------------------------------------------------------------
package loader_pkg;

   localparam int MEMORY_BITS = 11;
   localparam int MEMORY_SIZE = 2 ** MEMORY_BITS;
   localparam int HDR_BYTES   = 2;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      CKSUM,
      DONE,
      ERR
   } state_t;

   // A new load may only begin once the previous one has settled.
   function automatic logic accepts_start(input state_t s);
      return (s == IDLE) || (s == DONE) || (s == ERR);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Byte stream from the host link plus the instruction memory write port.
//   in_valid / in_data / in_ready : byte stream handshake
//   wr_en / wr_addr / wr_data     : one-word-per-strobe memory write
// Modports:
//   master : the loader (consumes bytes, drives the memory write)
//   slave  : the environment (host link and instruction memory)
// -----------------------------------------------------------------------------
interface imem_loader_if;
   import loader_pkg::*;

   logic                   in_valid;
   logic [7:0]             in_data;
   logic                   in_ready;
   logic                   wr_en;
   logic [MEMORY_BITS-1:0] wr_addr;
   logic [31:0]            wr_data;

   modport master (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Packs a byte stream into little-endian 32-bit words.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   clear       : drop any partial word (new load starting)
//   byte_valid  : byte_in is consumed this cycle
//   byte_in     : stream byte
//   word_valid  : byte_in is the 4th byte of a word (same cycle)
//   word        : assembled word, valid with word_valid
// -----------------------------------------------------------------------------
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  byte_idx;
   logic [23:0] shreg;    // first three bytes; the 4th comes straight from byte_in

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_idx <= 2'd0;
         shreg    <= 24'd0;
      end else if (clear) begin
         byte_idx <= 2'd0;
         shreg    <= 24'd0;
      end else if (byte_valid) begin
         byte_idx <= byte_idx + 2'd1;   // wraps 3 -> 0 at word boundary
         shreg    <= {byte_in, shreg[23:8]};
      end
   end

   assign word_valid = byte_valid && (byte_idx == 2'd3);
   assign word       = {byte_in, shreg};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a load frame from the host link, writes the words sequentially into
// instruction memory and holds the core in reset until the image is complete.
// Frame: count[7:0], count[15:8], count x 4 bytes (little-endian words),
//        then one XOR checksum byte when CHECKSUM_EN is defined.
// Optional feature macro: CHECKSUM_EN (checksum byte and XOR check).
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   start       : pulse that begins a load (only from IDLE, DONE or ERR)
//   bus         : byte stream in, memory write out (imem_loader_if.master)
//   cpu_hold    : core held in reset while high
//   done        : image loaded successfully
//   err         : load aborted (count too large, or bad checksum)
//   word_count  : count field latched from the header
// -----------------------------------------------------------------------------
module imem_loader
   import loader_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          err,
   output logic [15:0]   word_count
);

`ifdef CHECKSUM_EN
   localparam state_t TAIL_STATE = CKSUM;
`else
   localparam state_t TAIL_STATE = DONE;
`endif

   state_t               state;
   logic [7:0]           hdr_lo;
   logic [MEMORY_BITS:0] word_idx;   // one extra bit so MEMORY_SIZE words fit

   logic        accept;
   logic        start_ok;
   logic        pk_valid;
   logic [31:0] pk_word;
   logic [15:0] hdr_count;
   logic        last_word;

   assign accept    = bus.in_valid && bus.in_ready;
   assign start_ok  = start && accepts_start(state);
   assign hdr_count = {bus.in_data, hdr_lo};
   assign last_word = ((16'(word_idx) + 16'd1) == word_count);

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_ok),
      .byte_valid (accept && (state == DATA)),
      .byte_in    (bus.in_data),
      .word_valid (pk_valid),
      .word       (pk_word)
   );

`ifdef CHECKSUM_EN
   logic [7:0] cks;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cks <= 8'd0;
      end else if (start_ok) begin
         cks <= 8'd0;
      end else if (accept && (state == HDR0 || state == HDR1 || state == DATA)) begin
         cks <= cks ^ bus.in_data;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         hdr_lo      <= 8'd0;
         word_idx    <= '0;
         bus.in_ready <= 1'b0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= 32'd0;
         cpu_hold    <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         word_count  <= 16'd0;
      end else begin
         // NOTE: wr_en defaults low every cycle, so it can only ever be a
         // single-cycle strobe; branches below raise it for one word.
         bus.wr_en <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state        <= HDR0;
                  bus.in_ready <= 1'b1;
                  cpu_hold     <= 1'b1;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  word_idx     <= '0;
               end
            end
            HDR0: begin
               if (accept) begin
                  hdr_lo <= bus.in_data;
                  state  <= HDR1;
               end
            end
            HDR1: begin
               if (accept) begin
                  word_count <= hdr_count;
                  if (hdr_count > 16'(MEMORY_SIZE)) begin
                     state        <= ERR;
                     bus.in_ready <= 1'b0;
                     err          <= 1'b1;
                  end else if (hdr_count == 16'd0) begin
                     state        <= TAIL_STATE;
                     bus.in_ready <= (TAIL_STATE == CKSUM);
                     done         <= (TAIL_STATE == DONE);
                     cpu_hold     <= (TAIL_STATE != DONE);
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (bus.wr_en) begin
                  // Write cycle: advance the address and reopen the stream.
                  word_idx <= word_idx + 1'b1;
                  if (last_word) begin
                     state        <= TAIL_STATE;
                     bus.in_ready <= (TAIL_STATE == CKSUM);
                     done         <= (TAIL_STATE == DONE);
                     cpu_hold     <= (TAIL_STATE != DONE);
                  end else begin
                     bus.in_ready <= 1'b1;
                  end
               end else if (pk_valid) begin
                  bus.wr_en    <= 1'b1;
                  bus.wr_addr  <= word_idx[MEMORY_BITS-1:0];
                  bus.wr_data  <= pk_word;
                  bus.in_ready <= 1'b0;
               end
            end
`ifdef CHECKSUM_EN
            CKSUM: begin
               if (accept) begin
                  bus.in_ready <= 1'b0;
                  if ((cks ^ bus.in_data) == 8'd0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state        <= IDLE;
               bus.in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Frames are built as byte queues from a word buffer; the expected memory
// writes and final status follow from the frame rules. A negedge monitor
// checks every write strobe against the expected-write queue.
// -----------------------------------------------------------------------------
module tb_imem_loader;
   import loader_pkg::*;

`ifdef CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [15:0] word_count;

   imem_loader_if bus ();

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [MEMORY_BITS-1:0] addr;
      logic [31:0]            data;
      bit                     last;
   } wr_t;

   wr_t                    exp_q[$];
   logic [31:0]            mem  [0:MEMORY_SIZE-1];
   logic [31:0]            wbuf [0:MEMORY_SIZE-1];
   int                     nwrites   = 0;
   logic [MEMORY_BITS-1:0] last_addr = '0;
   bit                     prev_wr   = 1'b0;
   bit                     pend_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      wr_t e;
      if (pend_done) begin
         check("done_one_cycle_after_last_wr", {30'd0, cpu_hold, done}, 32'h1);
         pend_done = 1'b0;
      end
      if (rst && bus.wr_en) begin
         check("wr_en_not_back_to_back", {31'd0, prev_wr}, 32'd0);
         check("in_ready_low_during_wr", {31'd0, bus.in_ready}, 32'd0);
         check("cpu_hold_during_wr", {31'd0, cpu_hold}, 32'd1);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h required=none",
                     bus.wr_addr, bus.wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", {21'd0, bus.wr_addr}, {21'd0, e.addr});
            check("wr_data", bus.wr_data, e.data);
            if (e.last && !CK) pend_done = 1'b1;
         end
         mem[bus.wr_addr] = bus.wr_data;
         last_addr = bus.wr_addr;
         nwrites++;
      end
      prev_wr = bus.wr_en;
   end

   task automatic check_reset_values();
      check("rst_in_ready",   {31'd0, bus.in_ready}, 32'd0);
      check("rst_wr_en",      {31'd0, bus.wr_en},    32'd0);
      check("rst_wr_addr",    {21'd0, bus.wr_addr},  32'd0);
      check("rst_wr_data",    bus.wr_data,           32'd0);
      check("rst_cpu_hold",   {31'd0, cpu_hold},     32'd1);
      check("rst_done",       {31'd0, done},         32'd0);
      check("rst_err",        {31'd0, err},          32'd0);
      check("rst_word_count", {16'd0, word_count},   32'd0);
   endtask

   // Start pulse with a junk byte offered at the same time; it must not be taken.
   task automatic pulse_start();
      start        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      start        = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         failures++;
         $display("FAIL in_ready_timeout actual=0 required=1");
         bus.in_valid = 1'b0;
         return;
      end
      @(negedge clk);   // accepted on the posedge just passed
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         bus.in_data  = 8'($urandom);
         repeat (gap) @(negedge clk);
      end
   endtask

   // Build the frame for wbuf[0..cnt-1], predict writes and outcome, run it.
   task automatic run_frame(input int cnt, input int gap, input int mid_start, input bit bad_cks);
      logic [7:0] bq[$];
      logic [7:0] x = 8'h00;
      int         nw;
      bit         ok;
      int         n = 0;
      nw = (cnt > MEMORY_SIZE) ? 0 : cnt;
      bq.push_back(cnt[7:0]);
      bq.push_back(cnt[15:8]);
      for (int i = 0; i < nw; i++) begin
         for (int k = 0; k < 4; k++) bq.push_back(wbuf[i][8*k +: 8]);
         exp_q.push_back('{addr: i[MEMORY_BITS-1:0], data: wbuf[i], last: (i == nw - 1)});
      end
      foreach (bq[j]) x ^= bq[j];
      if (CK && cnt <= MEMORY_SIZE) bq.push_back(bad_cks ? (x ^ 8'h5A) : x);
      ok = (cnt <= MEMORY_SIZE) && !(CK && bad_cks);

      pulse_start();
      for (int i = 0; i < bq.size(); i++) begin
         send_byte(bq[i], gap);
         if (i == mid_start) begin
            bus.in_valid = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      while (!(done || err) && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("frame_done",       {31'd0, done},         {31'd0, ok});
      check("frame_err",        {31'd0, err},          {31'd0, !ok});
      check("frame_cpu_hold",   {31'd0, cpu_hold},     {31'd0, !ok});
      check("frame_in_ready",   {31'd0, bus.in_ready}, 32'd0);
      check("frame_word_count", {16'd0, word_count},   {16'd0, cnt[15:0]});
      check("frame_writes_outstanding", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int w0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic two-word image, back to back.
      wbuf[0] = 32'h12345678;
      wbuf[1] = 32'hDEADBEEF;
      w0 = nwrites;
      run_frame(2, 0, -1, 1'b0);
      check("basic_nwrites", nwrites - w0, 32'd2);
      check("basic_mem0", mem[0], 32'h12345678);
      check("basic_mem1", mem[1], 32'hDEADBEEF);

      // Same image with 5-cycle gaps and a start pulse inside DATA.
      mem[0] = 32'd0;
      mem[1] = 32'd0;
      w0 = nwrites;
      run_frame(2, 5, 4, 1'b0);
      check("gap_nwrites", nwrites - w0, 32'd2);
      check("gap_mem0", mem[0], 32'h12345678);
      check("gap_mem1", mem[1], 32'hDEADBEEF);

      // Count one beyond memory depth.
      w0 = nwrites;
      run_frame(2049, 0, -1, 1'b0);
      check("big_count_nwrites", nwrites - w0, 32'd0);
      check("big_count_word_count", {16'd0, word_count}, 32'h0801);

      // Empty image.
      run_frame(0, 1, -1, 1'b0);

`ifdef CHECKSUM_EN
      wbuf[0] = 32'h000000AA;
      run_frame(1, 0, -1, 1'b0);   // checksum 0xAB -> done
      run_frame(1, 0, -1, 1'b1);   // corrupted checksum -> err
`endif

      // Reset after three data bytes, then a clean one-word load.
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #2;
      check_reset_values();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values();
      wbuf[0] = 32'hCAFEF00D;
      w0 = nwrites;
      run_frame(1, 0, -1, 1'b0);
      check("rst_restart_nwrites", nwrites - w0, 32'd1);
      check("rst_restart_mem0", mem[0], 32'hCAFEF00D);

      // Randomized images.
      for (int r = 0; r < 6; r++) begin
         int cnt;
         cnt = $urandom_range(1, 24);
         for (int i = 0; i < cnt; i++) wbuf[i] = $urandom;
         w0 = nwrites;
         run_frame(cnt, $urandom_range(0, 3), -1, 1'b0);
         check("rand_nwrites", nwrites - w0, cnt);
      end

      // Full memory: last address 0x7FF, no wrap.
      for (int i = 0; i < MEMORY_SIZE; i++) wbuf[i] = i;
      w0 = nwrites;
      run_frame(MEMORY_SIZE, 0, -1, 1'b0);
      check("full_nwrites", nwrites - w0, 32'd2048);
      check("full_last_addr", {21'd0, last_addr}, 32'h7FF);
      check("full_mem_last", mem[11'h7FF], 32'h7FF);
      check("full_mem_first", mem[0], 32'h0);
      check("full_wr_addr_held", {21'd0, bus.wr_addr}, 32'h7FF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
